ts_sequence_tracker: RTL and testbench
======================================

TS_SEQUENCE_TRACKER -- requirements
Module: ts_sequence_tracker

Interface
REQ-001 SHALL have parameter TS_TARGET, default 8, the consecutive identical TS1/TS2 count that asserts the received flag (legal 1..15).
REQ-002 SHALL have parameter IDLE_TARGET, default 8, the consecutive idle-set count that asserts idle_rcvd_o (legal 1..15).
REQ-003 SHALL have ports:
  clk_i  in  1  clock; all logic on rising edge.
  rst_i  in  1  synchronous, active-high reset.
  ordered_set_i  in  128  captured ordered set; symbol n at bits [8n+7:8n]; sym1 link, sym2 lane, sym3 N_FTS, sym4 rate ID, sym5 training control.
  ts1_valid_i  in  1  one-cycle pulse: ordered_set_i holds a TS1.
  ts2_valid_i  in  1  one-cycle pulse: ordered_set_i holds a TS2.
  idle_valid_i  in  1  one-cycle pulse: idle/EIOS set detected.
  eieos_valid_i  in  1  one-cycle pulse: EIEOS detected.
  clear_i  in  1  LTSSM state change; discards all sequence history.
  ts1_count_o  out  4  current consecutive identical TS1 count.
  ts2_count_o  out  4  current consecutive identical TS2 count.
  ts1_rcvd_o  out  1  ts1_count_o >= TS_TARGET.
  ts2_rcvd_o  out  1  ts2_count_o >= TS_TARGET.
  idle_rcvd_o  out  1  idle count >= IDLE_TARGET.
  eieos_seen_o  out  1  sticky: EIEOS seen since last clear/reset.
  link_num_o  out  8  sym1 of the stored sequence reference.
  lane_num_o  out  8  sym2 of the stored reference.
  n_fts_o  out  8  sym3 of the stored reference.
  rate_id_o  out  8  sym4 of the stored reference.
  train_ctrl_o  out  8  sym5 of the stored reference.
  link_pad_o  out  1  link_num_o == PAD (8'hF7).
  lane_pad_o  out  1  lane_num_o == PAD (8'hF7).
  seq_error_o  out  1  one-cycle pulse: ts1_valid_i and ts2_valid_i asserted together.

Function
REQ-004 SHALL implement states ST_NONE, ST_TS1_SEQ, ST_TS2_SEQ, ST_IDLE_SEQ; all outputs registered, updated the cycle after the triggering input.
REQ-005 ST_NONE + ts1_valid_i -> ST_TS1_SEQ, store sym1-5 as reference, ts1_count=1, ts2_count=0, idle count=0; TS2 symmetric into ST_TS2_SEQ.
REQ-006 ST_TS1_SEQ + ts1_valid_i with sym1-5 equal to reference -> ts1_count +1, saturating at 15.
REQ-007 ST_TS1_SEQ + ts1_valid_i with any sym1-5 mismatch -> reload reference, ts1_count=1.
REQ-008 ST_TS1_SEQ + ts2_valid_i -> ST_TS2_SEQ, reference reloaded, ts2_count=1, ts1_count=0; ST_TS2_SEQ + TS1 symmetric.
REQ-009 idle_valid_i in any state -> ST_IDLE_SEQ, idle count +1 (saturating 15), ts1_count=ts2_count=0; reference registers retained.
REQ-010 ST_IDLE_SEQ + TS1 or TS2 -> idle count=0, then same action as from ST_NONE.
REQ-011 eieos_valid_i SHALL set eieos_seen_o and SHALL NOT change state, counts or reference (EIEOS interleaved in TS sequences).
REQ-012 ts1_valid_i and ts2_valid_i together -> both ignored, seq_error_o pulses, state/counts unchanged; idle_valid_i/eieos_valid_i in that cycle still processed.
REQ-013 idle_valid_i together with ts1/ts2_valid_i -> TS event wins, idle event discarded.
REQ-014 clear_i SHALL win over all same-cycle events: state ST_NONE, counts 0, eieos_seen_o 0, events that cycle discarded; reference outputs retained.
REQ-015 ts1_rcvd_o/ts2_rcvd_o/idle_rcvd_o SHALL be level outputs from the registered counts, remaining high while the count stays >= target.
REQ-016 With no input events, all outputs SHALL hold.

Reset
REQ-017 rst_i SHALL force ST_NONE, all counts 0, all rcvd flags 0, eieos_seen_o 0, seq_error_o 0, reference registers 8'h00 (link_pad_o=lane_pad_o=0).
REQ-018 rst_i SHALL take priority over clear_i and all events; mid-sequence reset loses all history.

Verification
REQ-019 8 identical TS1s (link 8'h00, lane 8'h01, N_FTS 8'h20), one every 4 cycles -> ts1_count_o 1..8; ts1_rcvd_o high the cycle after the 8th pulse; link_num_o=8'h00, lane_num_o=8'h01, n_fts_o=8'h20.
REQ-020 5 TS1s with lane PAD, 6th with lane 8'h02, then 7 more -> count restarts at 1 on the 6th, ts1_rcvd_o high after the 13th, lane_pad_o 1->0 at the 6th.
REQ-021 4 TS1s, EIEOS, 4 TS1s (all identical) -> ts1_count_o=8, ts1_rcvd_o=1, eieos_seen_o=1.
REQ-022 7 TS2s, clear_i coincident with 8th TS2 -> counts 0, ts2_rcvd_o stays 0; next TS2 -> ts2_count_o=1.
REQ-023 3 TS1s, then ts1_valid_i and ts2_valid_i together -> seq_error_o one-cycle pulse, ts1_count_o stays 3; then 8 idle_valid_i -> idle_rcvd_o=1, ts1_count_o=0.
REQ-024 rst_i asserted at ts1_count_o=6 -> next cycle all outputs at REQ-017 values.

Source files
------------

// File: rtl/ts_sequence_tracker.sv
// Tracks consecutive identical TS1/TS2 ordered sets and idle sets for the LTSSM.
// Holds the most recent sequence reference symbols and flags when the target counts are reached.
module ts_sequence_tracker #(
  parameter int TS_TARGET   = 8,
  parameter int IDLE_TARGET = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [127:0] ordered_set_i,
  input  logic         ts1_valid_i,
  input  logic         ts2_valid_i,
  input  logic         idle_valid_i,
  input  logic         eieos_valid_i,
  input  logic         clear_i,
  output logic [3:0]   ts1_count_o,
  output logic [3:0]   ts2_count_o,
  output logic         ts1_rcvd_o,
  output logic         ts2_rcvd_o,
  output logic         idle_rcvd_o,
  output logic         eieos_seen_o,
  output logic [7:0]   link_num_o,
  output logic [7:0]   lane_num_o,
  output logic [7:0]   n_fts_o,
  output logic [7:0]   rate_id_o,
  output logic [7:0]   train_ctrl_o,
  output logic         link_pad_o,
  output logic         lane_pad_o,
  output logic         seq_error_o
);

  localparam logic [3:0] TS_TGT   = 4'(TS_TARGET);
  localparam logic [3:0] IDLE_TGT = 4'(IDLE_TARGET);
  localparam logic [7:0] PAD      = 8'hF7;

  typedef enum logic [1:0] {
    ST_NONE,
    ST_TS1_SEQ,
    ST_TS2_SEQ,
    ST_IDLE_SEQ
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ts1_cnt_q, ts1_cnt_d;
  logic [3:0]  ts2_cnt_q, ts2_cnt_d;
  logic [3:0]  idle_cnt_q, idle_cnt_d;
  logic [39:0] ref_q, ref_d;
  logic        eieos_q, eieos_d;
  logic        err_q, err_d;

  logic [39:0] rx_syms;
  logic        ts1_only;
  logic        ts2_only;
  logic        sym_match;
  logic        unused_sym_bits;

  // Only symbols 1..5 identify a training sequence; COM and the tail are ignored.
  assign rx_syms         = ordered_set_i[47:8];
  assign unused_sym_bits = ^{ordered_set_i[127:48], ordered_set_i[7:0]};
  assign ts1_only        = ts1_valid_i & ~ts2_valid_i;
  assign ts2_only        = ts2_valid_i & ~ts1_valid_i;
  assign sym_match       = (rx_syms == ref_q);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_NONE;
      ts1_cnt_q  <= 4'd0;
      ts2_cnt_q  <= 4'd0;
      idle_cnt_q <= 4'd0;
      ref_q      <= 40'd0;
      eieos_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts1_cnt_q  <= ts1_cnt_d;
      ts2_cnt_q  <= ts2_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      ref_q      <= ref_d;
      eieos_q    <= eieos_d;
      err_q      <= err_d;
    end
  end

  // A simultaneous TS1+TS2 is ambiguous, so both are dropped while idle/EIEOS still count.
  always_comb begin
    state_d    = state_q;
    ts1_cnt_d  = ts1_cnt_q;
    ts2_cnt_d  = ts2_cnt_q;
    idle_cnt_d = idle_cnt_q;
    ref_d      = ref_q;
    eieos_d    = eieos_q;
    err_d      = 1'b0;
    if (clear_i) begin
      state_d    = ST_NONE;
      ts1_cnt_d  = 4'd0;
      ts2_cnt_d  = 4'd0;
      idle_cnt_d = 4'd0;
      eieos_d    = 1'b0;
    end else begin
      err_d   = ts1_valid_i & ts2_valid_i;
      eieos_d = eieos_q | eieos_valid_i;
      if (ts1_only) begin
        state_d    = ST_TS1_SEQ;
        ts2_cnt_d  = 4'd0;
        idle_cnt_d = 4'd0;
        if (state_q == ST_TS1_SEQ && sym_match) begin
          ts1_cnt_d = sat_inc(ts1_cnt_q);
        end else begin
          ts1_cnt_d = 4'd1;
          ref_d     = rx_syms;
        end
      end else if (ts2_only) begin
        state_d    = ST_TS2_SEQ;
        ts1_cnt_d  = 4'd0;
        idle_cnt_d = 4'd0;
        if (state_q == ST_TS2_SEQ && sym_match) begin
          ts2_cnt_d = sat_inc(ts2_cnt_q);
        end else begin
          ts2_cnt_d = 4'd1;
          ref_d     = rx_syms;
        end
      end else if (idle_valid_i) begin
        state_d    = ST_IDLE_SEQ;
        idle_cnt_d = sat_inc(idle_cnt_q);
        ts1_cnt_d  = 4'd0;
        ts2_cnt_d  = 4'd0;
      end
    end
  end

  always_comb begin
    ts1_count_o  = ts1_cnt_q;
    ts2_count_o  = ts2_cnt_q;
    ts1_rcvd_o   = (ts1_cnt_q >= TS_TGT);
    ts2_rcvd_o   = (ts2_cnt_q >= TS_TGT);
    idle_rcvd_o  = (idle_cnt_q >= IDLE_TGT);
    eieos_seen_o = eieos_q;
    seq_error_o  = err_q;
    link_num_o   = ref_q[7:0];
    lane_num_o   = ref_q[15:8];
    n_fts_o      = ref_q[23:16];
    rate_id_o    = ref_q[31:24];
    train_ctrl_o = ref_q[39:32];
    link_pad_o   = (ref_q[7:0] == PAD);
    lane_pad_o   = (ref_q[15:8] == PAD);
  end

endmodule

// File: tb/tb_ts_sequence_tracker.sv
// Bench for ts_sequence_tracker: directed training scenarios plus randomized traffic
// compared against a simple sequence-counting model.
module tb_ts_sequence_tracker;

  localparam int TS_TARGET   = 8;
  localparam int IDLE_TARGET = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [127:0] ordered_set_i = '0;
  logic         ts1_valid_i = 1'b0, ts2_valid_i = 1'b0, idle_valid_i = 1'b0;
  logic         eieos_valid_i = 1'b0, clear_i = 1'b0;
  logic [3:0]   ts1_count_o, ts2_count_o;
  logic         ts1_rcvd_o, ts2_rcvd_o, idle_rcvd_o, eieos_seen_o;
  logic [7:0]   link_num_o, lane_num_o, n_fts_o, rate_id_o, train_ctrl_o;
  logic         link_pad_o, lane_pad_o, seq_error_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 none, 1 TS1 run, 2 TS2 run, 3 idle run.
  int          m_mode, m_ts1, m_ts2, m_idle;
  logic [39:0] m_ref;
  bit          m_eieos, m_err;

  ts_sequence_tracker #(.TS_TARGET(TS_TARGET), .IDLE_TARGET(IDLE_TARGET)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ordered_set_i(ordered_set_i),
    .ts1_valid_i(ts1_valid_i), .ts2_valid_i(ts2_valid_i), .idle_valid_i(idle_valid_i),
    .eieos_valid_i(eieos_valid_i), .clear_i(clear_i),
    .ts1_count_o(ts1_count_o), .ts2_count_o(ts2_count_o),
    .ts1_rcvd_o(ts1_rcvd_o), .ts2_rcvd_o(ts2_rcvd_o), .idle_rcvd_o(idle_rcvd_o),
    .eieos_seen_o(eieos_seen_o), .link_num_o(link_num_o), .lane_num_o(lane_num_o),
    .n_fts_o(n_fts_o), .rate_id_o(rate_id_o), .train_ctrl_o(train_ctrl_o),
    .link_pad_o(link_pad_o), .lane_pad_o(lane_pad_o), .seq_error_o(seq_error_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] make_os(input logic [7:0] link, input logic [7:0] lane,
                                           input logic [7:0] nfts, input logic [7:0] rate,
                                           input logic [7:0] ctrl);
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    v[47:8] = {ctrl, rate, nfts, lane, link};
    return v;
  endfunction

  task automatic model_step(input bit t1, input bit t2, input bit idl, input bit eie,
                            input bit clr, input bit rs, input logic [127:0] os);
    int kind;
    if (rs) begin
      m_mode = 0; m_ts1 = 0; m_ts2 = 0; m_idle = 0; m_ref = '0; m_eieos = 0; m_err = 0;
    end else if (clr) begin
      m_mode = 0; m_ts1 = 0; m_ts2 = 0; m_idle = 0; m_eieos = 0; m_err = 0;
    end else begin
      m_err   = t1 && t2;
      m_eieos = m_eieos || eie;
      if (t1 != t2) begin
        kind = t1 ? 1 : 2;
        if (m_mode == kind && os[47:8] == m_ref) begin
          if (kind == 1) m_ts1 = (m_ts1 < 15) ? m_ts1 + 1 : 15;
          else           m_ts2 = (m_ts2 < 15) ? m_ts2 + 1 : 15;
        end else begin
          m_ref = os[47:8];
          m_ts1 = (kind == 1) ? 1 : 0;
          m_ts2 = (kind == 2) ? 1 : 0;
        end
        m_mode = kind;
        m_idle = 0;
      end else if (idl) begin
        m_mode = 3;
        m_idle = (m_idle < 15) ? m_idle + 1 : 15;
        m_ts1 = 0;
        m_ts2 = 0;
      end
    end
  endtask

  // Drives one cycle of inputs, advances the model, and returns #1 after the edge.
  task automatic apply_cycle(input bit t1, input bit t2, input bit idl, input bit eie,
                             input bit clr, input bit rs, input logic [127:0] os);
    ts1_valid_i = t1; ts2_valid_i = t2; idle_valid_i = idl;
    eieos_valid_i = eie; clear_i = clr; rst_i = rs; ordered_set_i = os;
    model_step(t1, t2, idl, eie, clr, rs, os);
    @(posedge clk_i);
    #1;
    ts1_valid_i = 0; ts2_valid_i = 0; idle_valid_i = 0;
    eieos_valid_i = 0; clear_i = 0; rst_i = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_cycle(0, 0, 0, 0, 0, 0, ordered_set_i);
  endtask

  task automatic test_reset();
    apply_cycle(0, 0, 0, 0, 0, 1, '0);
    n_checks++;
    if ({ts1_count_o, ts2_count_o, ts1_rcvd_o, ts2_rcvd_o, idle_rcvd_o, eieos_seen_o, seq_error_o} !== 13'd0) begin
      n_errors++;
      $display("[TB] FAIL reset_counts: got ts1=%0d ts2=%0d flags=%b%b%b%b%b expected all zero",
               ts1_count_o, ts2_count_o, ts1_rcvd_o, ts2_rcvd_o, idle_rcvd_o, eieos_seen_o, seq_error_o);
    end
    n_checks++;
    if ({link_num_o, lane_num_o, n_fts_o, rate_id_o, train_ctrl_o, link_pad_o, lane_pad_o} !== 42'd0) begin
      n_errors++;
      $display("[TB] FAIL reset_ref: got link=%h lane=%h nfts=%h pads=%b%b expected zero",
               link_num_o, lane_num_o, n_fts_o, link_pad_o, lane_pad_o);
    end
  endtask

  task automatic test_ts1_train();
    logic [127:0] os;
    os = make_os(8'h00, 8'h01, 8'h20, 8'h02, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      apply_cycle(1, 0, 0, 0, 0, 0, os);
      n_checks++;
      if (ts1_count_o !== 4'(i) || ts1_rcvd_o !== (i >= TS_TARGET)) begin
        n_errors++;
        $display("[TB] FAIL ts1_train_count: pulse %0d got count=%0d rcvd=%b expected count=%0d rcvd=%b",
                 i, ts1_count_o, ts1_rcvd_o, i, (i >= TS_TARGET));
      end
      idle_cycles(3);
    end
    n_checks++;
    if (link_num_o !== 8'h00 || lane_num_o !== 8'h01 || n_fts_o !== 8'h20 || ts1_rcvd_o !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL ts1_train_ref: got link=%h lane=%h nfts=%h rcvd=%b expected 00 01 20 1",
               link_num_o, lane_num_o, n_fts_o, ts1_rcvd_o);
    end
  endtask

  task automatic test_lane_pad();
    logic [127:0] os;
    apply_cycle(0, 0, 0, 0, 1, 0, ordered_set_i);
    os = make_os(8'h05, 8'hF7, 8'h10, 8'h02, 8'h00);
    for (int i = 1; i <= 13; i++) begin
      if (i == 6) os = make_os(8'h05, 8'h02, 8'h10, 8'h02, 8'h00);
      apply_cycle(1, 0, 0, 0, 0, 0, os);
      n_checks++;
      if (ts1_count_o !== 4'(i < 6 ? i : i - 5) || lane_pad_o !== (i < 6) ||
          ts1_rcvd_o !== (i == 13)) begin
        n_errors++;
        $display("[TB] FAIL lane_pad_seq: pulse %0d got count=%0d pad=%b rcvd=%b expected count=%0d pad=%b rcvd=%b",
                 i, ts1_count_o, lane_pad_o, ts1_rcvd_o, (i < 6 ? i : i - 5), (i < 6), (i == 13));
      end
    end
  endtask

  task automatic test_eieos_interleave();
    logic [127:0] os;
    apply_cycle(0, 0, 0, 0, 1, 0, ordered_set_i);
    os = make_os(8'h01, 8'h03, 8'h40, 8'h06, 8'h00);
    for (int i = 0; i < 4; i++) apply_cycle(1, 0, 0, 0, 0, 0, os);
    apply_cycle(0, 0, 0, 1, 0, 0, make_os(8'h99, 8'h99, 8'h99, 8'h99, 8'h99));
    n_checks++;
    if (ts1_count_o !== 4'd4 || eieos_seen_o !== 1'b1 || link_num_o !== 8'h01) begin
      n_errors++;
      $display("[TB] FAIL eieos_hold: got count=%0d eieos=%b link=%h expected 4 1 01",
               ts1_count_o, eieos_seen_o, link_num_o);
    end
    for (int i = 0; i < 4; i++) apply_cycle(1, 0, 0, 0, 0, 0, os);
    n_checks++;
    if (ts1_count_o !== 4'd8 || ts1_rcvd_o !== 1'b1 || eieos_seen_o !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL eieos_interleave: got count=%0d rcvd=%b eieos=%b expected 8 1 1",
               ts1_count_o, ts1_rcvd_o, eieos_seen_o);
    end
  endtask

  task automatic test_clear_ts2();
    logic [127:0] os;
    os = make_os(8'h02, 8'h00, 8'h30, 8'h02, 8'h00);
    for (int i = 0; i < 7; i++) apply_cycle(0, 1, 0, 0, 0, 0, os);
    n_checks++;
    if (ts2_count_o !== 4'd7 || ts1_count_o !== 4'd0) begin
      n_errors++;
      $display("[TB] FAIL ts2_build: got ts2=%0d ts1=%0d expected 7 0", ts2_count_o, ts1_count_o);
    end
    apply_cycle(0, 1, 0, 0, 1, 0, os);
    n_checks++;
    if (ts2_count_o !== 4'd0 || ts2_rcvd_o !== 1'b0 || eieos_seen_o !== 1'b0 || lane_num_o !== 8'h00 ||
        n_fts_o !== 8'h30) begin
      n_errors++;
      $display("[TB] FAIL clear_wins: got ts2=%0d rcvd=%b eieos=%b nfts=%h expected 0 0 0 30",
               ts2_count_o, ts2_rcvd_o, eieos_seen_o, n_fts_o);
    end
    apply_cycle(0, 1, 0, 0, 0, 0, os);
    n_checks++;
    if (ts2_count_o !== 4'd1) begin
      n_errors++;
      $display("[TB] FAIL clear_restart: got ts2=%0d expected 1", ts2_count_o);
    end
  endtask

  task automatic test_conflict_idle();
    logic [127:0] os;
    apply_cycle(0, 0, 0, 0, 1, 0, ordered_set_i);
    os = make_os(8'h07, 8'h01, 8'h18, 8'h02, 8'h00);
    for (int i = 0; i < 3; i++) apply_cycle(1, 0, 0, 0, 0, 0, os);
    apply_cycle(1, 1, 0, 0, 0, 0, make_os(8'h55, 8'h55, 8'h55, 8'h55, 8'h55));
    n_checks++;
    if (seq_error_o !== 1'b1 || ts1_count_o !== 4'd3 || ts2_count_o !== 4'd0 || link_num_o !== 8'h07) begin
      n_errors++;
      $display("[TB] FAIL conflict_pulse: got err=%b ts1=%0d ts2=%0d link=%h expected 1 3 0 07",
               seq_error_o, ts1_count_o, ts2_count_o, link_num_o);
    end
    for (int i = 1; i <= 8; i++) begin
      apply_cycle(0, 0, 1, 0, 0, 0, os);
      n_checks++;
      if (seq_error_o !== 1'b0 || ts1_count_o !== 4'd0 || idle_rcvd_o !== (i >= IDLE_TARGET)) begin
        n_errors++;
        $display("[TB] FAIL idle_run: idle %0d got err=%b ts1=%0d idle_rcvd=%b expected 0 0 %b",
                 i, seq_error_o, ts1_count_o, idle_rcvd_o, (i >= IDLE_TARGET));
      end
    end
    apply_cycle(0, 1, 1, 0, 0, 0, os);
    n_checks++;
    if (idle_rcvd_o !== 1'b0 || ts2_count_o !== 4'd1) begin
      n_errors++;
      $display("[TB] FAIL ts_beats_idle: got idle_rcvd=%b ts2=%0d expected 0 1", idle_rcvd_o, ts2_count_o);
    end
  endtask

  task automatic test_saturation();
    logic [127:0] os;
    apply_cycle(0, 0, 0, 0, 1, 0, ordered_set_i);
    os = make_os(8'hF7, 8'hF7, 8'h08, 8'h02, 8'h00);
    for (int i = 0; i < 17; i++) apply_cycle(1, 0, 0, 0, 0, 0, os);
    n_checks++;
    if (ts1_count_o !== 4'd15 || ts1_rcvd_o !== 1'b1 || link_pad_o !== 1'b1 || lane_pad_o !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL ts1_saturate: got count=%0d rcvd=%b pads=%b%b expected 15 1 11",
               ts1_count_o, ts1_rcvd_o, link_pad_o, lane_pad_o);
    end
  endtask

  task automatic test_mid_reset();
    logic [127:0] os;
    apply_cycle(0, 0, 0, 0, 1, 0, ordered_set_i);
    os = make_os(8'h03, 8'h04, 8'h20, 8'h02, 8'h01);
    apply_cycle(0, 0, 0, 1, 0, 0, os);
    for (int i = 0; i < 6; i++) apply_cycle(1, 0, 0, 0, 0, 0, os);
    n_checks++;
    if (ts1_count_o !== 4'd6 || eieos_seen_o !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL pre_reset: got count=%0d eieos=%b expected 6 1", ts1_count_o, eieos_seen_o);
    end
    apply_cycle(1, 0, 1, 1, 1, 1, os);
    n_checks++;
    if ({ts1_count_o, ts2_count_o, ts1_rcvd_o, ts2_rcvd_o, idle_rcvd_o, eieos_seen_o, seq_error_o,
         link_num_o, lane_num_o, n_fts_o, rate_id_o, train_ctrl_o, link_pad_o, lane_pad_o} !== 55'd0) begin
      n_errors++;
      $display("[TB] FAIL mid_reset: got ts1=%0d eieos=%b link=%h lane=%h ctrl=%h expected all zero",
               ts1_count_o, eieos_seen_o, link_num_o, lane_num_o, train_ctrl_o);
    end
  endtask

  task automatic test_random();
    logic [127:0] os;
    logic [7:0]   lk, ln;
    bit           t1, t2, idl, eie, clr, rs;
    os = make_os(8'h00, 8'h01, 8'h20, 8'h02, 8'h00);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        lk = ($urandom_range(0, 1) == 0) ? 8'hF7 : 8'(c);
        ln = ($urandom_range(0, 1) == 0) ? 8'hF7 : 8'h01;
        os = make_os(lk, ln, 8'h20, 8'(c % 3), 8'($urandom_range(0, 1)));
      end else begin
        os[127:48] = {$urandom, $urandom, 16'($urandom)};
      end
      t1  = ($urandom_range(0, 2) == 0);
      t2  = ($urandom_range(0, 5) == 0);
      idl = ($urandom_range(0, 4) == 0);
      eie = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 49) == 0);
      rs  = ($urandom_range(0, 99) == 0);
      apply_cycle(t1, t2, idl, eie, clr, rs, os);
      n_checks++;
      if (ts1_count_o !== 4'(m_ts1) || ts2_count_o !== 4'(m_ts2)) begin
        n_errors++;
        $display("[TB] FAIL rand_counts: cycle %0d got ts1=%0d ts2=%0d expected %0d %0d",
                 c, ts1_count_o, ts2_count_o, m_ts1, m_ts2);
      end
      n_checks++;
      if (ts1_rcvd_o !== (m_ts1 >= TS_TARGET) || ts2_rcvd_o !== (m_ts2 >= TS_TARGET) ||
          idle_rcvd_o !== (m_idle >= IDLE_TARGET)) begin
        n_errors++;
        $display("[TB] FAIL rand_flags: cycle %0d got rcvd=%b%b%b expected %b%b%b", c,
                 ts1_rcvd_o, ts2_rcvd_o, idle_rcvd_o,
                 (m_ts1 >= TS_TARGET), (m_ts2 >= TS_TARGET), (m_idle >= IDLE_TARGET));
      end
      n_checks++;
      if (eieos_seen_o !== m_eieos || seq_error_o !== m_err) begin
        n_errors++;
        $display("[TB] FAIL rand_status: cycle %0d got eieos=%b err=%b expected %b %b",
                 c, eieos_seen_o, seq_error_o, m_eieos, m_err);
      end
      n_checks++;
      if ({train_ctrl_o, rate_id_o, n_fts_o, lane_num_o, link_num_o} !== m_ref ||
          link_pad_o !== (m_ref[7:0] == 8'hF7) || lane_pad_o !== (m_ref[15:8] == 8'hF7)) begin
        n_errors++;
        $display("[TB] FAIL rand_ref: cycle %0d got %h pads=%b%b expected %h", c,
                 {train_ctrl_o, rate_id_o, n_fts_o, lane_num_o, link_num_o},
                 link_pad_o, lane_pad_o, m_ref);
      end
    end
  endtask

  initial begin
    m_mode = 0; m_ts1 = 0; m_ts2 = 0; m_idle = 0; m_ref = '0; m_eieos = 0; m_err = 0;
    @(negedge clk_i);
    test_reset();
    test_ts1_train();
    test_lane_pad();
    test_eieos_interleave();
    test_clear_ts2();
    test_conflict_idle();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
